// File: rtl/led_breath_sequencer_if.sv
// Host-side bundle for the breathing sequencer: start/stop control, per-run settings and status.
// Signal suffixes are given from the sequencer's point of view.
interface led_breath_sequencer_if;
    logic       start_i;
    logic       stop_i;
    logic [7:0] speed_i;
    logic [7:0] peak_i;
    logic [7:0] hold_i;
    logic [7:0] dutycycle_o;
    logic       busy_o;
    logic [1:0] state_o;
    logic       done_o;

    modport master (
        output start_i, stop_i, speed_i, peak_i, hold_i,
        input  dutycycle_o, busy_o, state_o, done_o
    );

    modport slave (
        input  start_i, stop_i, speed_i, peak_i, hold_i,
        output dutycycle_o, busy_o, state_o, done_o
    );
endinterface

// File: rtl/led_breath_sequencer.sv
// Breathing-pattern duty generator: fade-in, hold at peak, fade-out, optional automatic repeat.
// Define LED_BREATH_GAMMA_EN for a squared-law output ((duty*duty)>>8, one extra cycle of latency).
module led_breath_sequencer #(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned LOOP     = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    led_breath_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_HOLD = 2'd2,
        S_DOWN = 2'd3
    } state_t;

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam bit          LOOP_EN   = (LOOP != 0);

    state_t      state_q;
    logic [7:0]  duty_q;
    logic [7:0]  step_q;
    logic [7:0]  peak_q;
    logic [7:0]  hold_q;
    logic [7:0]  hcnt_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        busy_q;
    logic        done_q;
    logic        stop_q;
    logic        start_ok;
    logic        tick;
    logic [7:0]  up_duty_d;
    logic [7:0]  down_duty_d;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] lim);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[7:0];
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

    assign start_ok    = (state_q == S_IDLE) && bus.start_i && !bus.stop_i;
    assign tick        = busy_q && (cnt_q == TICK_LAST);
    assign up_duty_d   = sat_add(duty_q, step_q, peak_q);
    assign down_duty_d = sat_sub(duty_q, step_q);

    // Prescaler: free-runs only while a sequence is active, restarts on every accepted start.
    always_comb begin
        cnt_d = cnt_q;
        if (start_ok) begin
            cnt_d = 16'd0;
        end else if (busy_q) begin
            cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Per-run settings are frozen at start and survive loop restarts.
    always_ff @(posedge clk_i) begin
        if (start_ok) begin
            step_q <= (bus.speed_i == 8'd0) ? 8'd1 : bus.speed_i;
            peak_q <= bus.peak_i;
            hold_q <= bus.hold_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            duty_q  <= 8'd0;
            hcnt_q  <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        state_q <= S_UP;
                        busy_q  <= 1'b1;
                        duty_q  <= 8'd0;
                    end
                end
                S_UP: begin
                    if (bus.stop_i) begin
                        stop_q  <= 1'b1;
                        state_q <= S_DOWN;
                    end else if (tick) begin
                        duty_q <= up_duty_d;
                        if (up_duty_d == peak_q) begin
                            state_q <= S_HOLD;
                            hcnt_q  <= hold_q;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.stop_i) begin
                        stop_q  <= 1'b1;
                        state_q <= S_DOWN;
                    end else if (tick) begin
                        if (hcnt_q == 8'd0) begin
                            state_q <= S_DOWN;
                        end else begin
                            hcnt_q <= hcnt_q - 8'd1;
                        end
                    end
                end
                S_DOWN: begin
                    if (bus.stop_i) begin
                        stop_q <= 1'b1;
                    end
                    if (tick) begin
                        duty_q <= down_duty_d;
                        if (down_duty_d == 8'd0) begin
                            // A stop seen on this very edge still cancels the restart.
                            if (LOOP_EN && !stop_q && !bus.stop_i) begin
                                state_q <= S_UP;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                stop_q  <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.state_o = state_q;

`ifdef LED_BREATH_GAMMA_EN
    function automatic logic [7:0] gamma_sq(input logic [7:0] a);
        logic [15:0] prod;
        prod = 16'(a) * 16'(a);
        return prod[15:8];
    endfunction

    logic [7:0] gamma_q;
    logic       done_dly_q;

    // Output stage: squared duty, with done delayed to line up with the final zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gamma_q    <= 8'd0;
            done_dly_q <= 1'b0;
        end else begin
            gamma_q    <= gamma_sq(duty_q);
            done_dly_q <= done_q;
        end
    end

    assign bus.dutycycle_o = gamma_q;
    assign bus.done_o      = done_dly_q;
`else
    assign bus.dutycycle_o = duty_q;
    assign bus.done_o      = done_q;
`endif

endmodule

// File: tb/tb_led_breath_sequencer.sv
// Bench for led_breath_sequencer: three instances (TICK_DIV/LOOP variants) against a tick-list reference model.
`timescale 1ns/1ps
module tb_led_breath_sequencer;
    localparam int TD_A = 4;
    localparam int TD_B = 1;
    localparam int TD_C = 4;
`ifdef LED_BREATH_GAMMA_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic rst_a, rst_b, rst_c;
    int   n_chk, n_err;
    int   m_st[$];
    int   m_du[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    led_breath_sequencer_if if_a ();
    led_breath_sequencer_if if_b ();
    led_breath_sequencer_if if_c ();

    led_breath_sequencer #(.TICK_DIV(TD_A), .LOOP(0)) u_a (.clk_i(clk), .rst_i(rst_a), .bus(if_a));
    led_breath_sequencer #(.TICK_DIV(TD_B), .LOOP(0)) u_b (.clk_i(clk), .rst_i(rst_b), .bus(if_b));
    led_breath_sequencer #(.TICK_DIV(TD_C), .LOOP(1)) u_c (.clk_i(clk), .rst_i(rst_c), .bus(if_c));

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int td_of(input int u);
        case (u)
            0:       return TD_A;
            1:       return TD_B;
            default: return TD_C;
        endcase
    endfunction

    function automatic int out_map(input int d);
        return (LAT != 0) ? ((d * d) >> 8) : d;
    endfunction

    task automatic drive(input int u, input int st, input int sp, input int spd, input int pk, input int hd);
        case (u)
            0: begin
                if_a.start_i = st[0]; if_a.stop_i = sp[0];
                if_a.speed_i = 8'(spd); if_a.peak_i = 8'(pk); if_a.hold_i = 8'(hd);
            end
            1: begin
                if_b.start_i = st[0]; if_b.stop_i = sp[0];
                if_b.speed_i = 8'(spd); if_b.peak_i = 8'(pk); if_b.hold_i = 8'(hd);
            end
            default: begin
                if_c.start_i = st[0]; if_c.stop_i = sp[0];
                if_c.speed_i = 8'(spd); if_c.peak_i = 8'(pk); if_c.hold_i = 8'(hd);
            end
        endcase
    endtask

    task automatic sample(input int u, output int du, output int st, output int bz, output int dn);
        case (u)
            0:       begin du = if_a.dutycycle_o; st = if_a.state_o; bz = if_a.busy_o; dn = if_a.done_o; end
            1:       begin du = if_b.dutycycle_o; st = if_b.state_o; bz = if_b.busy_o; dn = if_b.done_o; end
            default: begin du = if_c.dutycycle_o; st = if_c.state_o; bz = if_c.busy_o; dn = if_c.done_o; end
        endcase
    endtask

    // Reference model: list of (state, linear duty) after each tick; entry 0 is the start.
    task automatic push(input int s, input int d);
        m_st.push_back(s);
        m_du.push_back(d);
    endtask

    task automatic add_down(input int from, input int step, input int end_st);
        int d;
        d = from;
        while (d > step) begin
            d -= step;
            push(3, d);
        end
        push(end_st, 0);
    endtask

    task automatic add_period(input int step, input int pk, input int hd, input int lp);
        int d;
        d = 0;
        while (d + step < pk) begin
            d += step;
            push(1, d);
        end
        push(2, pk);
        repeat (hd) push(2, pk);
        push(3, pk);
        add_down(pk, step, (lp != 0) ? 1 : 0);
    endtask

    task automatic build(input int spd, input int pk, input int hd, input int lp, input int stop_j);
        int step, e, d0;
        step = (spd == 0) ? 1 : spd;
        m_st.delete();
        m_du.delete();
        push(1, 0);
        if (lp != 0) begin
            while (m_st.size() < stop_j + 600) add_period(step, pk, hd, lp);
        end else begin
            add_period(step, pk, hd, lp);
        end
        if (stop_j >= 0) begin
            if (m_st[stop_j] == 3) begin
                e = stop_j + 1;
                while (m_du[e] != 0) e++;
                while (m_st.size() > e + 1) begin void'(m_st.pop_back()); void'(m_du.pop_back()); end
                m_st[e] = 0;
            end else begin
                d0 = m_du[stop_j];
                while (m_st.size() > stop_j + 1) begin void'(m_st.pop_back()); void'(m_du.pop_back()); end
                add_down(d0, step, 0);
            end
        end
    endtask

    task automatic run(input int u, input string nm, input int spd, input int pk, input int hd,
                       input int lp, input int stop_j, input int poke);
        int td, last, ncyc, k, kd, es, ed, edn, du, st, bz, dn, sp, ps, pspd, ppk, phd;
        td = td_of(u);
        build(spd, pk, hd, lp, stop_j);
        last = m_st.size() - 1;
        drive(u, 1, 0, spd, pk, hd);
        @(negedge clk);
        ncyc = last * td + LAT + 3;
        for (int c = 0; c < ncyc; c++) begin
            k  = (c / td > last) ? last : c / td;
            es = m_st[k];
            if (stop_j >= 0 && k == stop_j && c > k * td && (es == 1 || es == 2)) es = 3;
            if (c - LAT < 0) begin
                ed = 0;
            end else begin
                kd = ((c - LAT) / td > last) ? last : (c - LAT) / td;
                ed = out_map(m_du[kd]);
            end
            edn = (c == last * td + LAT) ? 1 : 0;
            sample(u, du, st, bz, dn);
            chk({nm, ".state"}, st, es);
            chk({nm, ".duty"}, du, ed);
            chk({nm, ".busy"}, bz, (es != 0) ? 1 : 0);
            chk({nm, ".done"}, dn, edn);
            sp   = (stop_j >= 0 && c == stop_j * td) ? 1 : 0;
            ps   = 0;
            pspd = spd; ppk = pk; phd = hd;
            if (poke != 0 && c < last * td) begin
                ps   = ($urandom_range(0, 3) == 0) ? 1 : 0;
                pspd = int'($urandom_range(0, 255));
                ppk  = int'($urandom_range(0, 255));
                phd  = int'($urandom_range(0, 255));
            end
            drive(u, ps, sp, pspd, ppk, phd);
            @(negedge clk);
        end
        drive(u, 0, 0, spd, pk, hd);
    endtask

    initial begin
        int du, st, bz, dn, spd, pk, hd, j, len;
        n_chk = 0;
        n_err = 0;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        for (int u = 0; u < 3; u++) drive(u, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            sample(u, du, st, bz, dn);
            chk("reset.state", st, 0);
            chk("reset.duty", du, 0);
            chk("reset.busy", bz, 0);
            chk("reset.done", dn, 0);
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);

        // IDLE collisions: stop alone, then start together with stop.
        drive(0, 0, 1, 64, 192, 2);
        @(negedge clk);
        drive(0, 1, 1, 64, 192, 2);
        @(negedge clk);
        drive(0, 0, 0, 64, 192, 2);
        for (int c = 0; c < 4; c++) begin
            sample(0, du, st, bz, dn);
            chk("idle_collide.state", st, 0);
            chk("idle_collide.busy", bz, 0);
            @(negedge clk);
        end

        run(0, "single", 64, 192, 2, 0, -1, 0);
        run(0, "start_in_busy", 64, 192, 2, 0, -1, 1);
        run(1, "sat_zero_step", 0, 3, 0, 0, -1, 0);
        run(1, "sat_clamp", 200, 150, 0, 0, -1, 0);
        run(1, "peak_full", 128, 255, 0, 0, -1, 0);
        run(2, "stop_in_hold", 32, 128, 10, 1, 6, 0);
        run(2, "loop", 128, 255, 0, 1, 11, 0);

        // Reset while holding at duty 200.
        drive(0, 1, 0, 100, 200, 5);
        @(negedge clk);
        drive(0, 0, 0, 100, 200, 5);
        repeat (9) @(negedge clk);
        sample(0, du, st, bz, dn);
        chk("rst_hold.pre_state", st, 2);
        chk("rst_hold.pre_duty", du, out_map(200));
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        sample(0, du, st, bz, dn);
        chk("rst_hold.state", st, 0);
        chk("rst_hold.duty", du, 0);
        chk("rst_hold.busy", bz, 0);
        chk("rst_hold.done", dn, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            sample(0, du, st, bz, dn);
            chk("rst_hold.after_done", dn, 0);
            chk("rst_hold.after_state", st, 0);
        end

        for (int i = 0; i < 4; i++) begin
            spd = int'($urandom_range(0, 255));
            pk  = int'($urandom_range(0, 255));
            hd  = int'($urandom_range(0, 15));
            build(spd, pk, hd, 0, -1);
            len = m_st.size() - 1;
            j   = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, len - 1));
            run(0, "rand_a", spd, pk, hd, 0, j, 1);
        end
        for (int i = 0; i < 5; i++) begin
            spd = int'($urandom_range(0, 255));
            pk  = int'($urandom_range(0, 255));
            hd  = int'($urandom_range(0, 15));
            run(1, "rand_b", spd, pk, hd, 0, -1, 1);
        end
        for (int i = 0; i < 4; i++) begin
            spd = int'($urandom_range(0, 255));
            pk  = int'($urandom_range(0, 255));
            hd  = int'($urandom_range(0, 15));
            j   = int'($urandom_range(0, 40));
            run(2, "rand_c", spd, pk, hd, 1, j, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/led_breath_sequencer.md
Name: led_breath_sequencer

Overview:
- Sequences LED brightness as a breathing pattern: fade-in, hold, fade-out, optional repeat.
- Produces the 8-bit duty-cycle word for the PWM generator, as an alternative to the free-running sine source.
- Rate is set by an internal tick prescaler on the system clock. Ramp step, peak level and hold length are sampled per cycle at start.

Parameters:
- TICK_DIV, 1000, system-clock cycles per sequencer tick; legal range 1..65535.
- LOOP, 0, 1 = restart fade-in automatically after fade-out until stopped; 0 = single shot.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  begin a sequence; honoured only in IDLE.
- stop_i  input  1  request graceful stop.
- speed_i  input  8  duty step per tick; 0 is treated as 1.
- peak_i  input  8  fade-in target duty.
- hold_i  input  8  extra ticks spent at peak.
- dutycycle_o  output  8  duty word to the PWM generator.
- busy_o  output  1  high whenever state != IDLE.
- state_o  output  2  encoding: 0 IDLE, 1 RAMP_UP, 2 HOLD, 3 RAMP_DOWN.
- done_o  output  1  one-cycle pulse on return to IDLE.

Behaviour:
- Fixed: one clock domain (clk_i). rst_i is synchronous and active-high.
- Reset: state IDLE, dutycycle_o=0, busy_o=0, state_o=0, done_o=0, tick counter=0, hold counter=0, stop latch=0.
- All outputs are registered.
- Tick counter:
  - Counts 0..TICK_DIV-1 only while busy.
  - Cleared when start is accepted.
  - tick asserts in the cycle where count == TICK_DIV-1, then count wraps to 0.
  - First tick occurs TICK_DIV cycles after start is accepted.
- IDLE:
  - start_i=1 and stop_i=0 → RAMP_UP.
  - On entry to RAMP_UP: capture step_q = max(speed_i,1), peak_q = peak_i, hold_q = hold_i; duty stays 0.
  - start_i and stop_i together → remain IDLE.
  - stop_i alone → no effect.
- RAMP_UP, on tick:
  - duty = min(duty+step_q, peak_q), computed 9-bit then saturated.
  - If the new duty == peak_q → HOLD with hold counter = hold_q.
  - peak_q=0 → HOLD on the first tick with duty 0.
- HOLD, on tick:
  - Hold counter == 0 → RAMP_DOWN; otherwise decrement.
  - HOLD therefore lasts hold_q+1 ticks.
- RAMP_DOWN, on tick:
  - duty = (duty > step_q) ? duty-step_q : 0.
  - When the new duty == 0:
    - LOOP=1 and stop latch clear → RAMP_UP with duty 0. Captured values are kept (no re-sampling).
    - Otherwise → IDLE, done_o=1 for exactly one cycle, stop latch cleared.
- stop_i while busy:
  - Sets the stop latch.
  - In RAMP_UP or HOLD, forces RAMP_DOWN at the next clock edge without waiting for a tick. Duty holds its current value.
  - In RAMP_DOWN, only suppresses looping.
- start_i while busy: ignored.
- Input changes while busy: ignored until the next start.
- Reset mid-sequence: immediate return to the reset values at the next edge. No done_o pulse.
- Latency: dutycycle_o updates in the cycle following the tick (1-cycle register latency).

Optional Feature:
- Macro: LED_BREATH_GAMMA_EN.
- Defined:
  - dutycycle_o = (duty*duty)>>8, using a 16-bit product, registered.
  - This adds one cycle of latency relative to state_o.
  - duty 255 gives 254; duty 128 gives 64; duty 0 gives 0.
  - done_o is delayed one cycle to stay aligned with the final output value 0.
- Not defined: dutycycle_o = duty (linear). No extra latency.

Test Plan:
- Single shot. TICK_DIV=4, LOOP=0, speed=64, peak=192, hold=2, 1-cycle start pulse.
  - Required: dutycycle_o sequence 64,128,192 (RAMP_UP), then 192 for 3 ticks (HOLD), then 128,64,0.
  - done_o pulses once at start-cycle+37; busy_o low afterwards.
- Saturation and zero step. speed=0, peak=3, hold=0, TICK_DIV=1.
  - Required: duty 1,2,3, one HOLD tick, then 2,1,0.
  - Second run with speed=200, peak=150: duty 150 (clamped), then 0.
- Stop. LOOP=1, speed=32, peak=128, hold=10, TICK_DIV=4; stop_i pulsed in HOLD.
  - Required: RAMP_DOWN on the next edge, duty 96,64,32,0, IDLE, done_o once, no restart.
- Loop. LOOP=1, speed=128, peak=255, hold=0; stop never asserted.
  - Required: 128,255,255(HOLD),127,0, then 128 again, repeating; done_o never asserts.
- Collisions. start_i and stop_i together in IDLE → stays IDLE. start_i during RAMP_DOWN → ignored, sequence completes normally. rst_i asserted in HOLD with duty 200 → dutycycle_o=0, state_o=0 next cycle, no done_o.
- Gamma (LED_BREATH_GAMMA_EN defined). speed=128, peak=255.
  - Required: dutycycle_o 64 then 254, each one cycle after the matching state/duty update.
  - done_o coincides with the output returning to 0.
